// File: rtl/reg_bank.sv
// reg_bank: 32 x 32-bit architectural register file with a per-register valid scoreboard.
// Optional write-to-read forwarding is enabled by defining REGBANK_WRITE_BYPASS_EN.
module reg_bank #(
    parameter int NUM_READ_PORTS = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int RADDR_WIDTH    = 7,
    localparam int IDX_W         = $clog2(NUM_REGS)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [DATA_WIDTH-1:0]                      write_data,
    input  logic [IDX_W-1:0]                           write_address,
    input  logic [NUM_READ_PORTS-1:0][RADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  read_data,
    input  logic [IDX_W-1:0]                           invalidate_register,
    output logic [NUM_REGS-1:0]                        register_valid
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:1]   valid_q;

    // Entry 0 is cleared by reset and never written, so it always holds zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_address != '0) begin
            regs[write_address] <= write_data;
        end
    end

    // The invalidate assignment comes last so it overrides a same-index writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '1;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (write_address == IDX_W'(i)) begin
                    valid_q[i] <= 1'b1;
                end
                if (invalidate_register == IDX_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign register_valid = {valid_q, 1'b1};

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] stored;
        logic                  unused_high_bits;

        assign idx              = read_addr[p][IDX_W-1:0];
        assign unused_high_bits = ^read_addr[p][RADDR_WIDTH-1:IDX_W];
        assign stored           = (idx == '0) ? '0 : regs[idx];

`ifdef REGBANK_WRITE_BYPASS_EN
        // Forward the in-flight writeback so a dependent read sees it this cycle.
        assign read_data[p] = (!reset && write_address != '0 && idx == write_address)
                              ? write_data : stored;
`else
        assign read_data[p] = stored;
`endif
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: randomized self-checking bench for reg_bank against an array-based model.
// Build with REGBANK_WRITE_BYPASS_EN defined to check the forwarding variant.
module tb_reg_bank;

    localparam int NP = 2;

    logic              clk;
    logic              reset;
    logic [31:0]       write_data;
    logic [4:0]        write_address;
    logic [NP-1:0][6:0]  read_addr;
    logic [NP-1:0][31:0] read_data;
    logic [4:0]        invalidate_register;
    logic [31:0]       register_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs  [32];
    bit          m_valid [32];

    reg_bank #(.NUM_READ_PORTS(NP)) dut (
        .clk                 (clk),
        .reset               (reset),
        .write_data          (write_data),
        .write_address       (write_address),
        .read_addr           (read_addr),
        .read_data           (read_data),
        .invalidate_register (invalidate_register),
        .register_valid      (register_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i]  = 32'd0;
            m_valid[i] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [6:0] addr);
        int idx;
        idx = int'(addr[4:0]);
        if (idx == 0) return 32'd0;
`ifdef REGBANK_WRITE_BYPASS_EN
        if (!reset && write_address != 0 && int'(write_address) == idx) return write_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] exp_valid();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_valid[i];
        v[0] = 1'b1;
        return v;
    endfunction

    // One rising edge; the model takes the write first, then the invalidate, so a
    // same-index invalidate leaves the register busy.
    task automatic clock_cycle();
        @(posedge clk);
        if (!reset) begin
            if (write_address != 0) begin
                m_regs[write_address]  = write_data;
                m_valid[write_address] = 1'b1;
            end
            if (invalidate_register != 0) m_valid[invalidate_register] = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        write_address       = 5'd0;
        write_data          = 32'd0;
        invalidate_register = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        read_addr = '0;
        model_reset();
        #100;
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a += NP) begin
            for (int p = 0; p < NP; p++) read_addr[p] = 7'(a + p) | 7'($urandom_range(0, 3) << 5);
            #1;
            for (int p = 0; p < NP; p++) begin
                total++;
                if (read_data[p] !== 32'd0) begin
                    bad++;
                    $display("[TB] FAIL reset_read r%0d: got %h expected 00000000", a + p, read_data[p]);
                end
            end
        end
        total++;
        if (register_valid !== 32'hFFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL reset_valid: got %h expected ffffffff", register_valid);
        end
    endtask

    task automatic test_invalidate();
        invalidate_register = 5'd5;
        read_addr[0] = 7'h65;
        clock_cycle();
        idle_inputs();
        #1;
        total++;
        if (register_valid !== 32'hFFFF_FFDF) begin
            bad++;
            $display("[TB] FAIL invalidate_valid: got %h expected ffffffdf", register_valid);
        end
        total++;
        if (read_data[0] !== 32'd0) begin
            bad++;
            $display("[TB] FAIL invalidate_data: got %h expected 00000000", read_data[0]);
        end
    endtask

    task automatic test_write();
        write_data    = 32'd255;
        write_address = 5'd5;
        read_addr[0]  = 7'h05;
        read_addr[NP-1] = 7'h25;
        #1;
`ifdef REGBANK_WRITE_BYPASS_EN
        total++;
        if (read_data[0] !== 32'd255) begin
            bad++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected 000000ff", read_data[0]);
        end
`else
        total++;
        if (read_data[0] !== 32'd0) begin
            bad++;
            $display("[TB] FAIL no_bypass_same_cycle: got %h expected 00000000", read_data[0]);
        end
`endif
        clock_cycle();
        idle_inputs();
        #1;
        total++;
        if (read_data[NP-1] !== 32'd255) begin
            bad++;
            $display("[TB] FAIL write_data_r5: got %h expected 000000ff", read_data[NP-1]);
        end
        total++;
        if (register_valid !== 32'hFFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL write_revalidate: got %h expected ffffffff", register_valid);
        end
    endtask

    task automatic test_zero_write();
        write_data          = 32'd255;
        write_address       = 5'd0;
        invalidate_register = 5'd2;
        read_addr[0]        = 7'h40;
        clock_cycle();
        idle_inputs();
        #1;
        total++;
        if (read_data[0] !== 32'd0) begin
            bad++;
            $display("[TB] FAIL zero_reg_read: got %h expected 00000000", read_data[0]);
        end
        total++;
        if (register_valid[2] !== 1'b0 || register_valid[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_reg_valid: got %h expected bit2=0 bit0=1", register_valid);
        end
    endtask

    task automatic test_same_index();
        write_data          = 32'd255;
        write_address       = 5'd4;
        invalidate_register = 5'd4;
        clock_cycle();
        idle_inputs();
        read_addr[0] = 7'h04;
        #1;
        total++;
        if (read_data[0] !== 32'd255) begin
            bad++;
            $display("[TB] FAIL same_index_data: got %h expected 000000ff", read_data[0]);
        end
        total++;
        if (register_valid !== 32'hFFFF_FFEB) begin
            bad++;
            $display("[TB] FAIL same_index_valid: got %h expected ffffffeb", register_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            write_data          = $urandom;
            write_address       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            invalidate_register = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            for (int p = 0; p < NP; p++) begin
                read_addr[p] = ($urandom_range(0, 4) == 0) ? {2'($urandom), write_address}
                                                           : 7'($urandom);
            end
            #1;
            for (int p = 0; p < NP; p++) begin
                total++;
                if (read_data[p] !== exp_read(read_addr[p])) begin
                    bad++;
                    $display("[TB] FAIL random_read n=%0d port=%0d addr=%h: got %h expected %h",
                             n, p, read_addr[p], read_data[p], exp_read(read_addr[p]));
                end
            end
            clock_cycle();
            total++;
            if (register_valid !== exp_valid()) begin
                bad++;
                $display("[TB] FAIL random_valid n=%0d: got %h expected %h",
                         n, register_valid, exp_valid());
            end
        end
    endtask

    task automatic test_reset_mid();
        write_data          = 32'hDEAD_BEEF;
        write_address       = 5'd7;
        invalidate_register = 5'd9;
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (register_valid !== 32'hFFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL reset_mid_valid: got %h expected ffffffff", register_valid);
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < 32; a += NP) begin
            for (int p = 0; p < NP; p++) read_addr[p] = 7'(a + p);
            #1;
            for (int p = 0; p < NP; p++) begin
                total++;
                if (read_data[p] !== 32'd0) begin
                    bad++;
                    $display("[TB] FAIL reset_mid_read r%0d: got %h expected 00000000", a + p, read_data[p]);
                end
            end
        end
        total++;
        if (register_valid !== 32'hFFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL reset_mid_valid_edge: got %h expected ffffffff", register_valid);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_invalidate();
        test_write();
        test_zero_write();
        test_same_index();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
